// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID register.
//
// Keeps at most one instruction-memory request outstanding. A word that comes back while
// IF/ID is occupied and stalled is parked in a hold register until decode frees up.
// Jumps and taken branches redirect the pc immediately; a response still in flight for the
// old path is flagged for discard and dropped when it arrives.
//
// Parameters
//   RESET_PC        first fetch address after reset
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   stall           decode cannot accept; IF/ID holds its contents
//   branch/jump     redirect requests with their targets (jump has priority)
//   imem_req/addr   fetch request towards instruction memory
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid/rdata  read response
//   instr, instr_valid, pc_plus4  IF/ID register contents
//   bubble_count    optional; present only when FETCH_PERF_CNT_EN is defined. Counts
//                   cycles spent in S_REQ/S_WAIT with instr_valid low; wraps.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] bubble_count,
`endif
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        iv_q, iv_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_free;
  logic        accept;
  logic        load_mem;
  logic        load_hold;

  assign redirect    = jump | branch;
  assign redirect_pc = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
  assign ifid_free   = ~iv_q | ~stall;
  assign accept      = imem_req & imem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      hold_q    <= '0;
      instr_q   <= '0;
      pp4_q     <= '0;
      iv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
      instr_q   <= instr_d;
      pp4_q     <= pp4_d;
      iv_q      <= iv_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    hold_d    = hold_q;
    load_mem  = 1'b0;
    load_hold = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // A request accepted in the same cycle as a redirect belongs to the old path.
        if (accept) begin
          state_d   = S_WAIT;
          discard_d = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d   = S_REQ;
          discard_d = 1'b0;
          if (!discard_q && !redirect) begin
            pc_d = pc_q + 32'd4;
            if (ifid_free) begin
              load_mem = 1'b1;
            end else begin
              hold_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall) begin
          load_hold = 1'b1;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect) pc_d = redirect_pc;

    // IF/ID: hold under stall, drain when consumed, refill on load, flush on redirect.
    instr_d = instr_q;
    pp4_d   = pp4_q;
    iv_d    = iv_q & stall;
    if (load_mem) begin
      instr_d = imem_rdata;
      pp4_d   = pc_q + 32'd4;
      iv_d    = 1'b1;
    end
    if (load_hold) begin
      // pc already advanced past the held word when it was parked
      instr_d = hold_q;
      pp4_d   = pc_q;
      iv_d    = 1'b1;
    end
    if (redirect) iv_d = 1'b0;
  end

  // Outputs
  always_comb begin
    imem_req    = (state_q == S_REQ) && !(iv_q && stall) && !reset;
    imem_addr   = pc_q;
    instr       = instr_q;
    instr_valid = iv_q;
    pc_plus4    = pp4_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= '0;
    end else if (state_q != S_HOLD && !iv_q) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bubble_count = bubble_q;
`endif

endmodule
